ps2_rx_periph: RTL



---
 rtl/ps2_rx_bus_if.sv | 23 ++
 rtl/ps2_rx_periph.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_bus_if.sv
// Read/write bus between the controller (master) and the PS/2 receiver (slave).
// data_to_rd is driven combinationally by the slave.
interface ps2_rx_bus_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
);
  logic              sel;
  logic              rw_req;
  logic              rw_rnw;
  logic [ADDR_W-1:0] rw_addr;
  logic [DATA_W-1:0] data_to_wr;
  logic [DATA_W-1:0] data_to_rd;

  modport master (
    output sel, rw_req, rw_rnw, rw_addr, data_to_wr,
    input  data_to_rd
  );

  modport slave (
    input  sel, rw_req, rw_rnw, rw_addr, data_to_wr,
    output data_to_rd
  );
endinterface

// File: rtl/ps2_rx_periph.sv
// Memory-mapped PS/2 keyboard receiver: frame decoder plus scancode FIFO.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity and flag STATUS[3].
module ps2_rx_periph #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_rx_bus_if.slave   bus,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Pin synchronizers; reset to 1 so an idle-high bus never looks like an edge
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  logic fall_c;
  logic data_s;
  assign fall_c = clk_prev & ~clk_sync[1];
  assign data_s = data_sync[1];

  // Inactivity counter, cleared by every PS/2 falling edge
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit_c;
  assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || fall_c) tmo_cnt <= '0;
    else if (!tmo_hit_c) tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       push_c;
  logic       ferr_set_c;
  logic       perr_set_c;
  logic       parity_bad_c;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit, par_nxt;
  assign parity_bad_c = ~(^{par_bit, shreg});
`else
  assign parity_bad_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= par_nxt;
`endif
    end
  end

  // Frame decoder; a real edge takes precedence over a coincident timeout
  always_comb begin
    state_nxt  = state;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    perr_set_c = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_nxt    = par_bit;
`endif
    if (fall_c) begin
      case (state)
        S_IDLE: begin
          if (!data_s) begin
            state_nxt = S_DATA;
            bit_nxt   = 3'd0;
          end else begin
            ferr_set_c = 1'b1;
          end
        end
        S_DATA: begin
          shreg_nxt = {data_s, shreg[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_nxt   = data_s;
`endif
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (!data_s)          ferr_set_c = 1'b1;
          else if (parity_bad_c) perr_set_c = 1'b1;
          else                  push_c     = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_hit_c) begin
      state_nxt  = S_IDLE;
      ferr_set_c = 1'b1;
    end
  end

  // Bus decode
  logic acc_c, rd_c, wr_c;
  logic addr_data_c, addr_stat_c;
  assign acc_c       = bus.sel & bus.rw_req;
  assign rd_c        = acc_c & bus.rw_rnw;
  assign wr_c        = acc_c & ~bus.rw_rnw;
  assign addr_data_c = (bus.rw_addr == ADDR_W'(0));
  assign addr_stat_c = (bus.rw_addr == ADDR_W'(1));

  // Scancode FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty_c, full_c, pop_c, do_push_c, ovr_set_c;

  assign empty_c   = (count == '0);
  assign full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c     = rd_c & addr_data_c & ~empty_c;
  assign do_push_c = push_c & ~rst & (~full_c | pop_c);
  assign ovr_set_c = push_c & full_c & ~pop_c;
  assign irq       = ~empty_c;

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error bits; a new event wins over a coincident clear
  logic [2:0] clr_c;
  logic       ovr, ferr, perr_rd_c;
  assign clr_c = (wr_c & addr_stat_c) ? bus.data_to_wr[4:2] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (ovr  & ~clr_c[0]) | ovr_set_c;
      ferr <= (ferr & ~clr_c[2]) | ferr_set_c;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic perr;
  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else     perr <= (perr & ~clr_c[1]) | perr_set_c;
  end
  assign perr_rd_c = perr;
  logic unused_wr;
  assign unused_wr = ^{bus.data_to_wr[DATA_W-1:5], bus.data_to_wr[1:0]};
`else
  assign perr_rd_c = 1'b0;
  logic unused_wr;
  assign unused_wr = ^{bus.data_to_wr[DATA_W-1:5], bus.data_to_wr[1:0], perr_set_c};
`endif

  // Combinational read mux
  always_comb begin
    bus.data_to_rd = '0;
    if (rd_c) begin
      case (bus.rw_addr)
        ADDR_W'(0): if (!empty_c) bus.data_to_rd = DATA_W'(mem[rd_ptr]);
        ADDR_W'(1): bus.data_to_rd = DATA_W'({ferr, perr_rd_c, ovr, full_c, ~empty_c});
        ADDR_W'(2): bus.data_to_rd = DATA_W'(count);
        default:    bus.data_to_rd = '0;
      endcase
    end
  end

endmodule
